data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data memory controller that succeeds the single-cycle word-only data memory. Adds byte/halfword/word loads and stores with sign or zero extension, byte-lane write enables, a valid/ready request handshake with configurable read latency, and alignment/range error reporting. It sits between the core's memory stage and the on-chip data RAM array, with one request outstanding at a time.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two, at least 4.
- `LATENCY`, 1: extra wait cycles before a response (0..7).
- `ADDR_W`, 32: request address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and words.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned, out of range, or had an illegal size.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT on accept when `LATENCY` > 0; IDLE → RESP on accept when `LATENCY` = 0.
  - WAIT → RESP when the wait counter reaches `LATENCY`-1.
  - RESP → WAIT or RESP on a new accept in the same cycle, otherwise RESP → IDLE.
- `req_ready` = 1 in IDLE and RESP, 0 in WAIT. A request is accepted when `req_valid` && `req_ready`.
- On accept, the controller registers `we`, `size`, `unsigned`, `addr[1:0]`, and the word index `addr[2+clog2(DEPTH)-1:2]`.
- Error conditions:
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0;
  - `size` = 11;
  - any address bit above `2+clog2(DEPTH)-1` set.
- An errored request performs no write and returns `rsp_err` = 1 with `rsp_rdata` = 0.
- Store: commits on the accept edge. Byte enables come from size and `addr[1:0]`, with data replicated onto the selected lanes. Unselected bytes are unchanged.
- Load: the word is read from the array at the edge entering RESP. The byte or half is selected by the registered `addr[1:0]`, then extended.
- Memory contents are not reset and are undefined until written.

## Timing
- If a request is accepted in cycle 0, `rsp_valid` is high in cycle 1+`LATENCY` for exactly one cycle. There is no response backpressure.
- Throughput is one request per `LATENCY`+1 cycles. Back-to-back issue is allowed by accepting in the RESP cycle.
- Read-after-write: a load accepted in a store's RESP cycle returns the stored data.
- Reset values: FSM in IDLE, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, wait counter 0. `req_ready` is 1 once reset deasserts.
- Reset mid-operation: the pending response is dropped and no `rsp_valid` is issued. A store accepted before reset stays committed.
- `rsp_rdata` and `rsp_err` are registered and hold their value until the next RESP cycle.

## Structure
- Package `dmem_pkg` holds:
  - the size encoding as constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state enum `dmem_state_t`;
  - the `dmem_be` helper function for byte-enable generation.
- Sub-module `dmem_align` is purely combinational:
  - store side: byte-enable and lane-replicated write data;
  - load side: lane extraction and sign/zero extension;
  - misalignment flag.
- The top level holds the FSM, wait counter, request registers, and the RAM array (`DEPTH` × 32, written per byte lane).

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 with `LATENCY`=1 → `rsp_valid` in cycle 2 after accept, `rdata` 0xDEADBEEF, `err` 0.
- Byte store 0x80 @0x13, then signed byte load @0x13 → 0xFFFFFF80; unsigned byte load → 0x00000080; word load @0x10 → 0x80ADBEEF.
- Half load @0x11 → `err` 1, `rdata` 0, and memory unchanged. Word store @0x1002 with `DEPTH`=1024 → `err` 1 and no write.
- Back-to-back: store in cycle 0 and load to the same address accepted in the RESP cycle → new data returned. `req_ready` is low exactly during WAIT cycles.
- `LATENCY`=0 and `LATENCY`=3 builds: response appears 1 and 4 cycles after accept respectively.
- Assert `rst_n` during WAIT of a load → no `rsp_valid`, outputs 0, `req_ready` 1 after release. A prior store is still readable.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : size encoding, FSM states and byte-enable helper for data_mem_ctrl
// Revision : 1.0
// ============================================================================
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;

   function automatic logic [3:0] dmem_be(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lo;
         SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
// dmem_align : store lane steering, load lane extraction/extension, alignment
// Revision   : 1.0
// ============================================================================
module dmem_align
   import dmem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lo,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata_rep,
   output logic        misaligned,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_lo,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_be = dmem_be(st_size, st_lo);
      case (st_size)
         SZ_BYTE: st_wdata_rep = {4{st_wdata[7:0]}};
         SZ_HALF: st_wdata_rep = {2{st_wdata[15:0]}};
         default: st_wdata_rep = st_wdata;
      endcase
      misaligned = ((st_size == SZ_HALF) && st_lo[0]) ||
                   ((st_size == SZ_WORD) && (st_lo != 2'b00));
   end

   always_comb begin
      ld_byte = 8'(ld_word >> {ld_lo, 3'b000});
      ld_half = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_size)
         SZ_BYTE: ld_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// data_mem_ctrl : byte/half/word data memory with valid/ready request handshake
// Revision      : 1.0
// ============================================================================
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int         IDX_W    = $clog2(DEPTH);
   localparam int         TOP      = 2 + IDX_W;
   localparam logic [2:0] LAST_CNT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   dmem_state_t      state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             we_q, we_d, uns_q, uns_d, err_q, err_d;
   logic [1:0]       size_q, size_d, lo_q, lo_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;

   logic [31:0]      mem [DEPTH];

   logic             w_accept, w_range_err, w_misaligned, w_err_in, w_mem_we, w_to_resp;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata_rep, w_ld_word, w_ld_data;
   logic             w_in_wait, w_ld_we, w_ld_uns, w_ld_err;
   logic [1:0]       w_ld_size, w_ld_lo;
   logic [IDX_W-1:0] w_wr_idx, w_ld_idx;

   generate
      if (ADDR_W > TOP) begin : g_range
         assign w_range_err = |req_addr[ADDR_W-1:TOP];
      end else begin : g_no_range
         assign w_range_err = 1'b0;
      end
   endgenerate

   assign req_ready = (state_q != ST_WAIT);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   assign w_accept  = req_valid && req_ready;
   assign w_err_in  = w_misaligned || (req_size == SZ_BAD) || w_range_err;
   assign w_mem_we  = w_accept && req_we && !w_err_in;
   assign w_wr_idx  = req_addr[TOP-1:2];

   // With zero latency the response is formed straight from the live request;
   // otherwise it comes from the fields captured at accept.
   assign w_in_wait = (state_q == ST_WAIT);
   assign w_ld_we   = w_in_wait ? we_q   : req_we;
   assign w_ld_size = w_in_wait ? size_q : req_size;
   assign w_ld_lo   = w_in_wait ? lo_q   : req_addr[1:0];
   assign w_ld_uns  = w_in_wait ? uns_q  : req_unsigned;
   assign w_ld_err  = w_in_wait ? err_q  : w_err_in;
   assign w_ld_idx  = w_in_wait ? idx_q  : w_wr_idx;
   assign w_ld_word = mem[w_ld_idx];
   assign w_to_resp = (w_in_wait && (cnt_q == LAST_CNT)) || ((LATENCY == 0) && w_accept);

   dmem_align u_align (
      .st_size      (req_size),
      .st_lo        (req_addr[1:0]),
      .st_wdata     (req_wdata),
      .st_be        (w_be),
      .st_wdata_rep (w_wdata_rep),
      .misaligned   (w_misaligned),
      .ld_size      (w_ld_size),
      .ld_lo        (w_ld_lo),
      .ld_unsigned  (w_ld_uns),
      .ld_word      (w_ld_word),
      .ld_data      (w_ld_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lo_d        = lo_q;
      idx_d       = idx_q;
      err_d       = err_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            state_d = ST_IDLE;
            if (w_accept) begin
               state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
               cnt_d   = 3'd0;
            end
         end
         ST_WAIT: begin
            if (cnt_q == LAST_CNT) state_d = ST_RESP;
            else                   cnt_d   = cnt_q + 3'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (w_accept) begin
         we_d   = req_we;
         size_d = req_size;
         uns_d  = req_unsigned;
         lo_d   = req_addr[1:0];
         idx_d  = w_wr_idx;
         err_d  = w_err_in;
      end
      if (w_to_resp) begin
         rsp_err_d   = w_ld_err;
         rsp_rdata_d = (w_ld_err || w_ld_we) ? 32'd0 : w_ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         we_q        <= 1'b0;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         lo_q        <= 2'b00;
         idx_q       <= '0;
         err_q       <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lo_q        <= lo_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Array is deliberately left out of reset so stores survive a reset pulse.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) mem[w_wr_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_data_mem_ctrl : three controllers (latency 0, 1, 3) against a byte model
// Revision         : 1.0
// ============================================================================
module tb_data_mem_ctrl;

   localparam int N     = 3;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid [N];
   logic        req_ready [N];
   logic        req_we [N];
   logic [1:0]  req_size [N];
   logic        req_unsigned [N];
   logic [31:0] req_addr [N];
   logic [31:0] req_wdata [N];
   logic        rsp_valid [N];
   logic [31:0] rsp_rdata [N];
   logic        rsp_err [N];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
   endfunction

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         data_mem_ctrl #(
            .DEPTH   (DEPTH),
            .LATENCY ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
            .ADDR_W  (32)
         ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g])
         );
      end
   endgenerate

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d lat=%0d cyc=%0d: got %h expected %h", name, k, lat_of(k), cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model: byte-addressed memory ----------------
   bit   [7:0]  mm [int];
   bit          pend [N];
   int          exp_cyc [N];
   logic [31:0] exp_rd [N];
   logic        exp_er [N];
   logic [31:0] last_rd [N];
   logic        last_er [N];

   function automatic void model_req(input int k, input logic we, input logic [1:0] sz, input logic uns,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
      int n = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
      er = (sz == 2'd3) || ((a % n) != 0) || (a >= DEPTH * 4);
      rd = 32'd0;
      if (!er) begin
         if (we) begin
            for (int i = 0; i < n; i++) mm[k * 65536 + int'(a) + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = mm[k * 65536 + int'(a) + i];
            if (!uns && n < 4 && rd[8*n-1])
               for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
         end
      end
   endfunction

   always @(negedge clk) begin : p_cmp
      logic        ev, rdy, er_m;
      logic [31:0] rd_m;
      for (int k = 0; k < N; k++) begin
         if (!rst_n) begin
            pend[k]    = 1'b0;
            last_rd[k] = 32'd0;
            last_er[k] = 1'b0;
         end
         ev = pend[k] && (exp_cyc[k] == cyc);
         if (ev) begin
            last_rd[k] = exp_rd[k];
            last_er[k] = exp_er[k];
         end
         chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(ev));
         chk("rsp_rdata", k, rsp_rdata[k], last_rd[k]);
         chk("rsp_err", k, 32'(rsp_err[k]), 32'(last_er[k]));
         if (rst_n) begin
            rdy = !(pend[k] && (cyc < exp_cyc[k]));
            chk("req_ready", k, 32'(req_ready[k]), 32'(rdy));
            if (ev) pend[k] = 1'b0;
            if (req_valid[k] && rdy) begin
               model_req(k, req_we[k], req_size[k], req_unsigned[k], req_addr[k], req_wdata[k], rd_m, er_m);
               pend[k]    = 1'b1;
               exp_cyc[k] = cyc + 1 + lat_of(k);
               exp_rd[k]  = rd_m;
               exp_er[k]  = er_m;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic wait_accept(input int k, output int acc);
      acc = -1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (req_ready[k]) begin
            acc = cyc;
            break;
         end
      end
   endtask

   task automatic wait_rsp(input int k, input int acc, output logic [31:0] rd, output logic er, output int lat);
      rd  = 32'd0;
      er  = 1'b0;
      lat = -1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (rsp_valid[k]) begin
            rd  = rsp_rdata[k];
            er  = rsp_err[k];
            lat = cyc - acc;
            break;
         end
      end
      chk("rsp_timeout", k, 32'(acc >= 0 && lat >= 0), 32'd1);
   endtask

   task automatic drive(input int k, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid[k]    = 1'b1;
      req_we[k]       = we;
      req_size[k]     = sz;
      req_unsigned[k] = uns;
      req_addr[k]     = a;
      req_wdata[k]    = wd;
   endtask

   task automatic do_req(input int k, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
      int acc, lat;
      @(posedge clk); #1;
      drive(k, we, sz, uns, a, wd);
      wait_accept(k, acc);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      wait_rsp(k, acc, rd, er, lat);
      chk("latency", k, lat, 1 + lat_of(k));
   endtask

   task automatic expect_ld(input int k, input string nm, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] rd;
      logic        er;
      do_req(k, 1'b0, sz, uns, a, 32'd0, rd, er);
      chk({nm, "_rdata"}, k, rd, exp_d);
      chk({nm, "_err"}, k, 32'(er), 32'(exp_e));
   endtask

   task automatic expect_st(input int k, input string nm, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd, input logic exp_e);
      logic [31:0] rd;
      logic        er;
      do_req(k, 1'b1, sz, 1'b0, a, wd, rd, er);
      chk({nm, "_rdata"}, k, rd, 32'd0);
      chk({nm, "_err"}, k, 32'(er), 32'(exp_e));
   endtask

   task automatic b2b(input int k, input logic [31:0] a, input logic [31:0] wd);
      int          acc1, acc2, lat;
      logic [31:0] rd;
      logic        er;
      @(posedge clk); #1;
      drive(k, 1'b1, 2'b10, 1'b0, a, wd);
      wait_accept(k, acc1);
      @(posedge clk); #1;
      drive(k, 1'b0, 2'b10, 1'b0, a, 32'd0);
      wait_accept(k, acc2);
      chk("b2b_issue_gap", k, acc2 - acc1, 1 + lat_of(k));
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      wait_rsp(k, acc2, rd, er, lat);
      chk("b2b_rdata", k, rd, wd);
      chk("b2b_err", k, 32'(er), 32'd0);
   endtask

   task automatic run_seq(input int k);
      expect_st(k, "st_w10", 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
      expect_ld(k, "ld_w10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
      expect_st(k, "st_b13", 2'b00, 32'h13, 32'h00000080, 1'b0);
      expect_ld(k, "ld_b13s", 2'b00, 1'b0, 32'h13, 32'hFFFFFF80, 1'b0);
      expect_ld(k, "ld_b13u", 2'b00, 1'b1, 32'h13, 32'h00000080, 1'b0);
      expect_ld(k, "ld_w10b", 2'b10, 1'b0, 32'h10, 32'h80ADBEEF, 1'b0);
      expect_ld(k, "ld_h11", 2'b01, 1'b0, 32'h11, 32'h0, 1'b1);
      expect_ld(k, "ld_w10c", 2'b10, 1'b0, 32'h10, 32'h80ADBEEF, 1'b0);
      expect_st(k, "st_w0", 2'b10, 32'h0, 32'h11223344, 1'b0);
      expect_st(k, "st_w1002", 2'b10, 32'h1002, 32'hCAFEF00D, 1'b1);
      expect_st(k, "st_w1000", 2'b10, 32'h1000, 32'hCAFEF00D, 1'b1);
      expect_ld(k, "ld_w0", 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0);
      expect_st(k, "st_h20", 2'b01, 32'h20, 32'h0000F00D, 1'b0);
      expect_st(k, "st_h22", 2'b01, 32'h22, 32'hFFFF1234, 1'b0);
      expect_ld(k, "ld_h20s", 2'b01, 1'b0, 32'h20, 32'hFFFFF00D, 1'b0);
      expect_ld(k, "ld_h20u", 2'b01, 1'b1, 32'h20, 32'h0000F00D, 1'b0);
      expect_ld(k, "ld_h22s", 2'b01, 1'b0, 32'h22, 32'h00001234, 1'b0);
      expect_ld(k, "ld_w20", 2'b10, 1'b0, 32'h20, 32'h1234F00D, 1'b0);
      expect_ld(k, "ld_b21u", 2'b00, 1'b1, 32'h21, 32'h000000F0, 1'b0);
      expect_ld(k, "ld_b21s", 2'b00, 1'b0, 32'h21, 32'hFFFFFFF0, 1'b0);
      expect_ld(k, "ld_sz3", 2'b11, 1'b0, 32'h20, 32'h0, 1'b1);
      b2b(k, 32'h40, 32'h5A5AA5A5);
   endtask

   initial begin : p_global_timeout
      #400000;
      $display("FAIL global_timeout: got cyc=%0d expected completion", cyc);
      $fatal(1, "bench timed out");
   end

   initial begin : p_main
      int acc;
      rst_n = 1'b1;
      for (int k = 0; k < N; k++) drive(k, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      for (int k = 0; k < N; k++) req_valid[k] = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < N; k++) run_seq(k);

      // reset while a latency-1 load sits in its wait cycle
      @(posedge clk); #1;
      drive(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
      wait_accept(1, acc);
      chk("rst_load_accepted", 1, 32'(acc >= 0), 32'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      chk("rst_in_wait_ready", 1, 32'(req_ready[1]), 32'd0);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);

      expect_ld(1, "post_rst_w10", 2'b10, 1'b0, 32'h10, 32'h80ADBEEF, 1'b0);
      expect_ld(2, "post_rst_w20", 2'b10, 1'b0, 32'h20, 32'h1234F00D, 1'b0);
      expect_ld(0, "post_rst_w40", 2'b10, 1'b0, 32'h40, 32'h5A5AA5A5, 1'b0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
